// File: rtl/clk_div_pwm_if.sv
// Configuration bus for clk_div_pwm: load strobe, period/duty/rate fields and
// the pending flag reported back to the programming side.
interface clk_div_pwm_if #(
  parameter int CNT_W = 8
);
  logic             cfg_load;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_duty;
  logic [1:0]       cfg_sel;
  logic             cfg_pending;

  modport master (
    output cfg_load,
    output cfg_period,
    output cfg_duty,
    output cfg_sel,
    input  cfg_pending
  );

  modport slave (
    input  cfg_load,
    input  cfg_period,
    input  cfg_duty,
    input  cfg_sel,
    output cfg_pending
  );
endinterface

// File: rtl/clk_div_pwm.sv
// Single-clock prescaler with /2../16 taps used as step enables, driving a
// double-buffered period/duty PWM generator.
module clk_div_pwm #(
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  clk_div_pwm_if.slave   cfg,
  output logic [3:0]     div_out,
  output logic           and_out,
  output logic           pwm_out,
  output logic           period_tick
);

  logic [3:0]       pre_reg,       pre_next;
  logic [CNT_W-1:0] pcnt_reg,      pcnt_next;
  logic [CNT_W-1:0] p_act_reg,     p_act_next;
  logic [CNT_W-1:0] d_act_reg,     d_act_next;
  logic [1:0]       sel_act_reg,   sel_act_next;
  logic [CNT_W-1:0] p_pend_reg,    p_pend_next;
  logic [CNT_W-1:0] d_pend_reg,    d_pend_next;
  logic [1:0]       sel_pend_reg,  sel_pend_next;
  logic             pending_reg,   pending_next;
  logic             tick_reg,      tick_next;

  logic [3:0] tap_ones;
  logic       step;
  logic       wrap;

  // tap_ones[k]: the low k prescaler bits are all ones, i.e. the last clock of
  // a 2^k-clock step interval.
  assign tap_ones[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_tap
      assign tap_ones[gi+1] = &pre_reg[gi:0];
    end
  endgenerate

  assign step = ena & tap_ones[sel_act_reg];
  assign wrap = step & (pcnt_reg == p_act_reg);

  always_comb begin
    pre_next      = pre_reg;
    pcnt_next     = pcnt_reg;
    p_act_next    = p_act_reg;
    d_act_next    = d_act_reg;
    sel_act_next  = sel_act_reg;
    p_pend_next   = p_pend_reg;
    d_pend_next   = d_pend_reg;
    sel_pend_next = sel_pend_reg;
    pending_next  = pending_reg;
    tick_next     = wrap;

    if (ena) begin
      pre_next = pre_reg + 4'd1;
    end

    if (step) begin
      pcnt_next = wrap ? '0 : pcnt_reg + 1'b1;
    end

    // Config only changes at a period boundary; a load on that same cycle
    // bypasses the pending registers so it is never delayed a full period.
    if (wrap) begin
      if (cfg.cfg_load) begin
        p_act_next   = cfg.cfg_period;
        d_act_next   = cfg.cfg_duty;
        sel_act_next = cfg.cfg_sel;
      end else if (pending_reg) begin
        p_act_next   = p_pend_reg;
        d_act_next   = d_pend_reg;
        sel_act_next = sel_pend_reg;
      end
      pending_next = 1'b0;
    end else if (cfg.cfg_load) begin
      p_pend_next   = cfg.cfg_period;
      d_pend_next   = cfg.cfg_duty;
      sel_pend_next = cfg.cfg_sel;
      pending_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_reg      <= '0;
      pcnt_reg     <= '0;
      p_act_reg    <= '0;
      d_act_reg    <= '0;
      sel_act_reg  <= '0;
      p_pend_reg   <= '0;
      d_pend_reg   <= '0;
      sel_pend_reg <= '0;
      pending_reg  <= 1'b0;
      tick_reg     <= 1'b0;
    end else begin
      pre_reg      <= pre_next;
      pcnt_reg     <= pcnt_next;
      p_act_reg    <= p_act_next;
      d_act_reg    <= d_act_next;
      sel_act_reg  <= sel_act_next;
      p_pend_reg   <= p_pend_next;
      d_pend_reg   <= d_pend_next;
      sel_pend_reg <= sel_pend_next;
      pending_reg  <= pending_next;
      tick_reg     <= tick_next;
    end
  end

  // All outputs decode registers only, so they are free of input-driven glitches.
  assign div_out         = pre_reg;
  assign and_out         = pre_reg[0] & pre_reg[2];
  assign pwm_out         = (pcnt_reg < d_act_reg);
  assign period_tick     = tick_reg;
  assign cfg.cfg_pending = pending_reg;

endmodule

// File: doc/clk_div_pwm.md
# clk_div_pwm

Synchronous divider and PWM stage that sits directly downstream of the ripple clock divider. It replaces the ripple-clocked divide-by-2/4/8/16 chain with a single-clock prescaler whose taps act as clock enables. It drives a programmable period/duty PWM output plus the divided square waves and their AND combination. Configuration is double-buffered so that reprogramming never produces a truncated or runt period.

## Interface

Parameters:
- CNT_W, 8, width of period counter, period and duty fields

Ports:
- clk, in, 1, sole clock; all state on rising edge
- rst_n, in, 1, asynchronous active-low reset
- ena, in, 1, count enable; low freezes prescaler and period counter
- cfg_load, in, 1, one-cycle strobe; captures cfg_period/cfg_duty/cfg_sel into pending registers
- cfg_period, in, CNT_W, period minus one (P); period length is P+1 steps
- cfg_duty, in, CNT_W, high steps per period (D)
- cfg_sel, in, 2, step rate: step every 2^sel enabled clocks (1, 2, 4, 8)
- cfg_pending, out, 1, pending config not yet applied
- div_out, out, 4, synchronous /2, /4, /8, /16 square waves (bit k = prescaler bit k)
- and_out, out, 1, div_out[0] & div_out[2]
- pwm_out, out, 1, PWM waveform
- period_tick, out, 1, one-clock pulse after each period wrap

## Operation

- Prescaler: 4-bit counter `pre`, increments by 1 mod 16 on every clk with ena=1. div_out = pre.
- Step strobe: step = ena & (sel_act==0 ? 1 : pre[sel_act-1:0] all ones), evaluated before the increment.
- Period counter `pcnt` (CNT_W bits):
  - On step with pcnt != P_act: pcnt+1.
  - On step with pcnt == P_act: wrap. pcnt goes to 0.
- Wrap applies config:
  - If cfg_pending=1, or cfg_load=1 in the same cycle, P_act/D_act/sel_act take the pending values; a same-cycle load bypasses pending and wins.
  - cfg_pending clears.
- cfg_load on a non-wrap cycle: pending registers overwritten (last load wins); cfg_pending set. cfg_load is accepted regardless of ena.
- pwm_out = (pcnt < D_act); combinational decode of registers only, glitch-free.
  - D=0 gives a constant 0.
  - D ≥ P+1 gives a constant 1.
- period_tick: registered; high in the clk following any wrap step. Consecutive wraps (P_act=0, sel_act=0, ena=1) hold it high continuously.
- ena=0: pre, pcnt, active config frozen; outputs hold; no wrap, so pending config waits.
- Arithmetic: unsigned throughout; compare uses full CNT_W; no saturation needed.

## Timing

- Reset values, asynchronous:
  - pre=0, pcnt=0.
  - P_act=0, D_act=0, sel_act=0.
  - Pending registers 0.
  - cfg_pending=0, period_tick=0, div_out=0, and_out=0, pwm_out=0.
- Reset deassertion: first rising edge with ena=1 increments pre and wraps pcnt, because P_act=0.
- Config latency:
  - A load is visible on cfg_pending one clk after the load edge.
  - It becomes active at the first wrap step at or after the load cycle.
  - Worst case: (P_act+1)·2^sel_act enabled clocks.
- pwm_out changes in the same clk as pcnt. period_tick lags the wrap edge by one clk.
- Reset mid-period: everything returns to reset values immediately and pending config is discarded.

## Test plan

- Reset/idle: hold rst_n=0, ena=1 → all outputs 0. Release → div_out counts 1, 2, 3…; and_out=1 exactly when pre[0] & pre[2]; pwm_out stays 0; period_tick high continuously from the 2nd clk.
- Basic PWM: load P=9, D=3, sel=0 → after the next wrap, pwm_out is high for 3 clks and low for 7; period_tick pulses every 10 clks.
- Prescaled: load P=9, D=3, sel=2 → pwm_out is high 12 clks and low 28; period_tick every 40 clks, aligned to pre[1:0]=3 steps.
- Double buffering: mid-period of P=9, D=3, load P=4, D=4, then P=4, D=1 → current period completes unchanged; cfg_pending=1 until the wrap; next periods are 5 clks with 1 clk high.
- Edge values:
  - D=0 → pwm_out constant 0.
  - D=20, P=9 → pwm_out constant 1.
  - cfg_load coincident with a wrap → applied that wrap; cfg_pending stays 0.
- ena gating / async reset: drop ena for 7 clks mid-period → pre, pcnt and pwm_out frozen and the period is stretched by exactly 7 clks. Assert rst_n low between edges → outputs clear immediately without waiting for clk.
